// File: rtl/writeback_queue_if.sv
// Producer/register-file bundle for the writeback queue: result handshake,
// register-file write port, and read-select snooping with forwarding.
interface writeback_queue_if #(
  parameter int N     = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_da;
  logic [N-1:0]  in_d;
  logic          hold;
  logic [N-1:0]  D;
  logic [4:0]    DA;
  logic          write;
  logic [4:0]    SA;
  logic [4:0]    SB;
  logic          fwdA_hit;
  logic          fwdB_hit;
  logic [N-1:0]  fwdA;
  logic [N-1:0]  fwdB;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_da, in_d, hold, SA, SB,
    input  in_ready, D, DA, write, fwdA_hit, fwdB_hit, fwdA, fwdB, count
  );

  modport slave (
    input  in_valid, in_da, in_d, hold, SA, SB,
    output in_ready, D, DA, write, fwdA_hit, fwdB_hit, fwdA, fwdB, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback FIFO in front of the register file; pending entries are
// snooped by the SA/SB read selects and the youngest match is forwarded.
module wbq_slot_match (
  input  logic       occ,
  input  logic [4:0] da,
  input  logic [4:0] sa,
  input  logic [4:0] sb,
  output logic       hit_a,
  output logic       hit_b
);
  assign hit_a = occ && (da == sa) && (sa != 5'd31);
  assign hit_b = occ && (da == sb) && (sb != 5'd31);
endmodule

module writeback_queue #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  writeback_queue_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] XZR = 5'd31;

  logic [AW-1:0]             head, tail;
  logic [CW-1:0]             cnt;
  logic [DEPTH-1:0][4:0]     da_q;
  logic [DEPTH-1:0][N-1:0]   d_q;
  logic [DEPTH-1:0]          occ, hit_a, hit_b;
  logic                      push, pop;

  assign wb.in_ready = (cnt < CW'(DEPTH));
  assign wb.write    = (cnt != '0) && !wb.hold;
  assign wb.count    = cnt;
  assign wb.D        = (cnt != '0) ? d_q[head]  : '0;
  assign wb.DA       = (cnt != '0) ? da_q[head] : XZR;

  // XZR results finish the handshake but never occupy a slot
  assign push = wb.in_valid && wb.in_ready && (wb.in_da != XZR);
  assign pop  = wb.write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      da_q[tail] <= wb.in_da;
      d_q[tail]  <= wb.in_d;
    end
  end

  // slot i is live when its distance from head is below the occupancy
  always_comb begin
    logic [AW-1:0] age;
    age = '0;
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age    = AW'(i) - head;
      occ[i] = ({1'b0, age} < cnt);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    wbq_slot_match u_match (
      .occ   (occ[g]),
      .da    (da_q[g]),
      .sa    (wb.SA),
      .sb    (wb.SB),
      .hit_a (hit_a[g]),
      .hit_b (hit_b[g])
    );
  end

  // walk oldest to youngest so the last match seen wins
  always_comb begin
    logic [AW-1:0] idx;
    idx     = '0;
    wb.fwdA = '0;
    wb.fwdB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (hit_a[idx]) wb.fwdA = d_q[idx];
      if (hit_b[idx]) wb.fwdB = d_q[idx];
    end
  end

  assign wb.fwdA_hit = |hit_a;
  assign wb.fwdB_hit = |hit_b;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a scoreboard records every enqueued
// result and each register-file write is matched against it in order.
module tb_writeback_queue;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]   da;
    logic [N-1:0] d;
  } wb_item_t;

  logic clock;
  logic reset;
  int   vectors = 0;
  int   fails   = 0;
  wb_item_t sb[$];

  writeback_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();

  writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // edge monitor: retire against the scoreboard, then record new accepts
  always @(posedge clock) begin
    if (reset) begin
      if (bus.write) begin
        if (sb.size() == 0) begin
          chk("spurious_write", 64'(bus.DA), 64'd31);
          chk("spurious_write_flag", 64'(bus.write), 64'd0);
        end else begin
          wb_item_t e;
          e = sb.pop_front();
          chk("wr_da", 64'(bus.DA), 64'(e.da));
          chk("wr_d", bus.D, e.d);
        end
      end
      if (bus.in_valid && bus.in_ready && bus.in_da != 5'd31) begin
        wb_item_t e;
        e.da = bus.in_da;
        e.d  = bus.in_d;
        sb.push_back(e);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_da    = '0;
    bus.in_d     = '0;
    bus.hold     = 1'b0;
    bus.SA       = 5'd0;
    bus.SB       = 5'd0;

    // reset state
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_D", bus.D, 64'd0);
    chk("rst_DA", 64'(bus.DA), 64'd31);
    chk("rst_fwdA_hit", 64'(bus.fwdA_hit), 64'd0);
    chk("rst_fwdB", bus.fwdB, 64'd0);
    cyc(1);
    reset = 1'b1;

    // single write, empty queue
    cyc(1);
    bus.in_valid = 1'b1; bus.in_da = 5'd5; bus.in_d = 64'h1234;
    cyc(1);
    bus.in_valid = 1'b0;
    #1;
    chk("one_write", 64'(bus.write), 64'd1);
    chk("one_DA", 64'(bus.DA), 64'd5);
    chk("one_D", bus.D, 64'h1234);
    chk("one_count", 64'(bus.count), 64'd1);
    cyc(1); #1;
    chk("one_count_after", 64'(bus.count), 64'd0);
    chk("one_write_after", 64'(bus.write), 64'd0);
    chk("one_DA_after", 64'(bus.DA), 64'd31);

    // fill under hold, then drain with da=5 waiting for space
    bus.hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      bus.in_valid = 1'b1; bus.in_da = 5'(i); bus.in_d = 64'h100 + 64'(i);
      #1;
      chk("fill_ready", 64'(bus.in_ready), (i <= 4) ? 64'd1 : 64'd0);
    end
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_write_held", 64'(bus.write), 64'd0);
    bus.hold = 1'b0;
    #1;
    chk("drain_write", 64'(bus.write), 64'd1);
    chk("drain_DA1", 64'(bus.DA), 64'd1);
    cyc(1); #1;
    chk("drain_count3", 64'(bus.count), 64'd3);
    chk("drain_ready", 64'(bus.in_ready), 64'd1);
    chk("drain_DA2", 64'(bus.DA), 64'd2);
    cyc(1);
    bus.in_valid = 1'b0;
    #1;
    chk("drain_count_swap", 64'(bus.count), 64'd3);
    chk("drain_DA3", 64'(bus.DA), 64'd3);
    cyc(4); #1;
    chk("drain_empty", 64'(bus.count), 64'd0);

    // XZR result is accepted and dropped
    bus.SA = 5'd31;
    bus.in_valid = 1'b1; bus.in_da = 5'd31; bus.in_d = 64'hFFFF;
    #1;
    chk("xzr_ready", 64'(bus.in_ready), 64'd1);
    cyc(1);
    bus.in_valid = 1'b0;
    #1;
    chk("xzr_count", 64'(bus.count), 64'd0);
    chk("xzr_write", 64'(bus.write), 64'd0);
    chk("xzr_fwdA_hit", 64'(bus.fwdA_hit), 64'd0);

    // youngest-match forwarding; unaccepted input is never forwarded
    bus.hold = 1'b1; bus.SA = 5'd7; bus.SB = 5'd3;
    cyc(1);
    bus.in_valid = 1'b1; bus.in_da = 5'd7; bus.in_d = 64'hA;
    #1;
    chk("fwd_no_inflight", 64'(bus.fwdA_hit), 64'd0);
    cyc(1); bus.in_da = 5'd7; bus.in_d = 64'hB;
    cyc(1); bus.in_da = 5'd3; bus.in_d = 64'hC;
    cyc(1); bus.in_valid = 1'b0;
    #1;
    chk("fwd_count", 64'(bus.count), 64'd3);
    chk("fwdA_hit", 64'(bus.fwdA_hit), 64'd1);
    chk("fwdA_young", bus.fwdA, 64'hB);
    chk("fwdB_hit", 64'(bus.fwdB_hit), 64'd1);
    chk("fwdB", bus.fwdB, 64'hC);
    bus.hold = 1'b0;
    cyc(2); #1;
    chk("fwd_retired_hitA", 64'(bus.fwdA_hit), 64'd0);
    chk("fwd_retired_A", bus.fwdA, 64'd0);
    chk("fwd_still_hitB", 64'(bus.fwdB_hit), 64'd1);
    cyc(1); #1;
    chk("fwd_empty", 64'(bus.count), 64'd0);
    bus.SA = 5'd0; bus.SB = 5'd0;

    // streaming push+pop across pointer wrap
    for (int i = 0; i < 3 * DEPTH; i++) begin
      bus.in_valid = 1'b1; bus.in_da = 5'(i % 31); bus.in_d = {$urandom, $urandom};
      #1;
      if (i > 0) chk("stream_count", 64'(bus.count), 64'd1);
      cyc(1);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("stream_tail", 64'(bus.count), 64'd1);
    cyc(1); #1;
    chk("stream_empty", 64'(bus.count), 64'd0);

    // reset mid-operation discards pending entries
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_da = 5'(10 + i); bus.in_d = 64'hBAD0 + 64'(i);
      cyc(1);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("mid_count3", 64'(bus.count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_write", 64'(bus.write), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_DA", 64'(bus.DA), 64'd31);
    sb.delete();
    cyc(1);
    reset = 1'b1; bus.hold = 1'b0;
    bus.in_valid = 1'b1; bus.in_da = 5'd9; bus.in_d = 64'h99;
    cyc(1);
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_write", 64'(bus.write), 64'd1);
    chk("post_rst_DA", 64'(bus.DA), 64'd9);
    cyc(4); #1;
    chk("post_rst_empty", 64'(bus.count), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
